// File: rtl/sodor_mem_pkg.sv
// Shared encodings and lane helpers for the sodor scratchpad memory.
// Store byte-enable/replication and load extension live here so RTL and align logic agree.
package sodor_mem_pkg;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  // Load context captured at the request edge, consumed one cycle later.
  typedef struct packed {
    logic [2:0]  typ;
    logic [1:0]  off;
    logic [31:0] word;
  } ld_reg_t;

  function automatic logic [3:0] mem_be(input logic [2:0] typ, input logic [1:0] off);
    case (typ)
      MT_B, MT_BU: mem_be = 4'b0001 << off;
      MT_H, MT_HU: mem_be = off[1] ? 4'b1100 : 4'b0011;
      default:     mem_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mem_st_rep(input logic [2:0] typ, input logic [31:0] d);
    case (typ)
      MT_B, MT_BU: mem_st_rep = {4{d[7:0]}};
      MT_H, MT_HU: mem_st_rep = {2{d[15:0]}};
      default:     mem_st_rep = d;
    endcase
  endfunction

  function automatic logic [31:0] mem_ld_ext(input logic [2:0] typ, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (typ)
      MT_B:    mem_ld_ext = {{24{b[7]}}, b};
      MT_BU:   mem_ld_ext = {24'h0, b};
      MT_H:    mem_ld_ext = {{16{h[15]}}, h};
      MT_HU:   mem_ld_ext = {16'h0, h};
      default: mem_ld_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/sodor_mem_load_align.sv
// Combinational lane select and sign/zero extension of a registered load word.
module sodor_mem_load_align
  import sodor_mem_pkg::*;
(
  input  logic [2:0]  i_typ,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  assign o_data = mem_ld_ext(i_typ, i_off, i_word);

endmodule

// File: rtl/sodor_scratchpad_mem.sv
// Dual-port scratchpad: read-only imem port and byte-masked dmem port, 1-cycle responses.
// Optional SCRATCH_TOHOST_EN adds a tohost register decoded at TOHOST_ADDR.
module sodor_scratchpad_mem
  import sodor_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_imem_req_valid,
  input  logic [31:0] io_imem_req_bits_addr,
  output logic        io_imem_resp_valid,
  output logic [31:0] io_imem_resp_bits_data,
  input  logic        io_dmem_req_valid,
  input  logic [31:0] io_dmem_req_bits_addr,
  input  logic [31:0] io_dmem_req_bits_data,
  input  logic        io_dmem_req_bits_fcn,
  input  logic [2:0]  io_dmem_req_bits_typ,
  output logic        io_dmem_resp_valid,
  output logic [31:0] io_dmem_resp_bits_data
`ifdef SCRATCH_TOHOST_EN
  ,
  output logic [31:0] tohost,
  output logic        tohost_valid
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_imem_vld;
  logic [31:0]      r_imem_data;
  logic             r_dmem_vld;
  ld_reg_t          r_ld;

  logic [IDX_W-1:0] w_iidx, w_didx;
  logic [1:0]       w_off;
  logic             w_st, w_ld, w_arr_we;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_ld_word;

  assign w_iidx  = io_imem_req_bits_addr[IDX_W+1:2];
  assign w_didx  = io_dmem_req_bits_addr[IDX_W+1:2];
  assign w_off   = io_dmem_req_bits_addr[1:0];
  assign w_st    = io_dmem_req_valid && (io_dmem_req_bits_fcn == M_XWR);
  assign w_ld    = io_dmem_req_valid && (io_dmem_req_bits_fcn == M_XRD);
  assign w_be    = mem_be(io_dmem_req_bits_typ, w_off);
  assign w_wdata = mem_st_rep(io_dmem_req_bits_typ, io_dmem_req_bits_data);

`ifdef SCRATCH_TOHOST_EN
  logic [31:0] r_tohost;
  logic        r_tohost_vld;
  logic        w_th_hit, w_th_st;

  // Only a full-word store claims tohost; narrower stores fall through to the array.
  assign w_th_hit  = (io_dmem_req_bits_addr == TOHOST_ADDR);
  assign w_th_st   = w_st && w_th_hit && (w_be == 4'b1111);
  assign w_arr_we  = w_st && !w_th_st;
  assign w_ld_word = w_th_hit ? r_tohost : r_mem[w_didx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tohost     <= '0;
      r_tohost_vld <= 1'b0;
    end else if (w_th_st) begin
      r_tohost <= io_dmem_req_bits_data;
      if (io_dmem_req_bits_data != '0) r_tohost_vld <= 1'b1;
    end
  end

  assign tohost       = r_tohost;
  assign tohost_valid = r_tohost_vld;

  logic w_unused;
  assign w_unused = ^{io_imem_req_bits_addr[1:0], io_imem_req_bits_addr[31:IDX_W+2]};
`else
  assign w_arr_we  = w_st;
  assign w_ld_word = r_mem[w_didx];

  logic w_unused;
  assign w_unused = ^{io_imem_req_bits_addr[1:0], io_imem_req_bits_addr[31:IDX_W+2],
                      io_dmem_req_bits_addr[31:IDX_W+2], TOHOST_ADDR};
`endif

  // Array is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clock) begin
    if (reset && w_arr_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_didx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_imem_vld  <= 1'b0;
      r_imem_data <= '0;
      r_dmem_vld  <= 1'b0;
      r_ld        <= '0;
    end else begin
      r_imem_vld <= io_imem_req_valid;
      r_dmem_vld <= io_dmem_req_valid;
      if (io_imem_req_valid) r_imem_data <= r_mem[w_iidx];
      if (w_ld) r_ld <= '{typ: io_dmem_req_bits_typ, off: w_off, word: w_ld_word};
    end
  end

  // Load context only moves on loads, so store responses keep the previous data.
  sodor_mem_load_align u_align (
    .i_typ  (r_ld.typ),
    .i_off  (r_ld.off),
    .i_word (r_ld.word),
    .o_data (io_dmem_resp_bits_data)
  );

  assign io_imem_resp_valid     = r_imem_vld;
  assign io_imem_resp_bits_data = r_imem_data;
  assign io_dmem_resp_valid     = r_dmem_vld;

endmodule

// File: doc/sodor_scratchpad_mem.md
Name: sodor_scratchpad_mem

Overview:
Dual-port on-chip scratchpad that acts as the responder for the 2-stage core's instruction and data memory request interfaces. It serves instruction fetches on one read-only port, and loads and stores on a read/write data port. Each port has one-cycle registered response latency. Sized for formal/contract benches, so depth is small and parameterised.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost register; used only with SCRATCH_TOHOST_EN.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
io_imem_req_valid  in  1  fetch request.
io_imem_req_bits_addr  in  32  fetch byte address.
io_imem_resp_valid  out  1  fetch response valid.
io_imem_resp_bits_data  out  32  fetched instruction.
io_dmem_req_valid  in  1  data request.
io_dmem_req_bits_addr  in  32  data byte address.
io_dmem_req_bits_data  in  32  store data, right-aligned.
io_dmem_req_bits_fcn  in  1  0 = load (M_XRD), 1 = store (M_XWR).
io_dmem_req_bits_typ  in  3  1 = B, 2 = H, 3 = W, 5 = BU, 6 = HU; others are treated as W.
io_dmem_resp_valid  out  1  load/store completion.
io_dmem_resp_bits_data  out  32  load data, extended.

Behaviour:
- Indexing: word index = addr[2+:log2(DEPTH_WORDS)]; higher address bits are ignored, so addresses wrap modulo the depth.
- Both ports are always ready; there is no backpressure.
- Reset (reset == 0): io_imem_resp_valid = 0, io_dmem_resp_valid = 0, both data outputs = 0, and the pending-load registers are cleared. The array is not reset.
- Reset asserted mid-request drops the in-flight response.
- Imem port, cycle N req_valid: in cycle N+1, resp_valid = 1 and resp_data = mem[idx].
- Imem port without a request: resp_valid = 0 and resp_data holds its last value.
- Dmem load in cycle N:
  - Cycle N+1: resp_valid = 1.
  - Raw word is selected by addr[1:0] lane, using the offset and typ registered in cycle N.
  - B: sign-extend byte at lane addr[1:0]. BU: zero-extend that byte.
  - H: sign-extend half at addr[1]. HU: zero-extend that half.
  - W: whole word; addr[1:0] is ignored.
- Dmem store in cycle N: write occurs at the clock edge ending cycle N, and resp_valid = 1 in cycle N+1.
  - Store byte enables: B/BU write the byte at addr[1:0]; H/HU write half at addr[1]; W writes all four bytes.
  - Store data is replicated across lanes (byte x4, half x2) before masking.
  - For stores, resp_data holds its previous value.
- Misalignment (e.g. H at addr[0] = 1, W at addr[1:0] != 0) is not flagged here, because the core detects it. Low bits beyond the lane selection are ignored.
- Same-cycle imem read and dmem store to the same word: imem returns the old data (read-before-write).
- Back-to-back dmem store then load to the same word in consecutive cycles: the load returns the new data.
- Pipelining: one request per port per cycle; responses return in request order.

Optional Feature:
SCRATCH_TOHOST_EN
- Defined: adds outputs tohost (32 bits) and tohost_valid (1 bit), both reset to 0.
  - A W store to TOHOST_ADDR (full 32-bit compare) updates tohost and does not write the array.
  - tohost_valid is set sticky on the first nonzero tohost write.
  - Loads from TOHOST_ADDR return tohost.
- Undefined: no extra ports; TOHOST_ADDR is unused and is an ordinary array location.

Decomposition:
- Shared package sodor_mem_pkg holds:
  - typ encodings: MT_B, MT_H, MT_W, MT_BU, MT_HU.
  - fcn encodings: M_XRD, M_XWR.
  - functions for byte-enable generation and load extension.
- One natural sub-module, sodor_mem_load_align: combinational lane selection and sign/zero extension from the registered offset/typ.

Test Plan:
- Reset released; store W 0xDEADBEEF to 0x40; imem fetch 0x40 next cycle -> io_imem_resp_valid = 1, data 0xDEADBEEF one cycle later.
- Store B 0x80 to 0x43, then load B 0x43 -> 0xFFFFFF80. Load BU 0x43 -> 0x00000080. Load W 0x40 -> 0x80ADBEEF.
- Store H 0x1234 to 0x42, then load HU 0x42 -> 0x00001234. Load W 0x40 -> 0x1234BEEF.
- Same cycle: imem fetch 0x40 and dmem store W 0x11111111 to 0x40 -> imem returns the old word. A following fetch returns 0x11111111.
- Address wrap with DEPTH_WORDS = 1024: store W 0xA5A5A5A5 to 0x1000_0004 -> load W 0x4 returns 0xA5A5A5A5.
- Assert reset with a load pending -> io_dmem_resp_valid = 0 in the next cycle and data = 0.
- With SCRATCH_TOHOST_EN: store W 1 to TOHOST_ADDR -> tohost = 1, tohost_valid = 1, array unchanged.
